// File: rtl/mem_arb_pkg.sv
// Shared types for the IFU / load-store memory-port arbiter.
// States, requester ids and the fixed fetch length.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } state_e;

  typedef enum logic {
    OWN_IF,
    OWN_LS
  } owner_e;

  localparam logic [3:0] FETCH_WLEN = 4'd8;

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selection between IFU and LSU requests.
// MEM_ARB_RR_EN selects round-robin, otherwise fixed LSU priority.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   if_req,
  input  logic   ls_req,
  input  owner_e last_owner,
  output logic   grant_valid,
  output owner_e grant_owner
);

  assign grant_valid = if_req | ls_req;

`ifdef MEM_ARB_RR_EN
  always_comb begin
    grant_owner = OWN_IF;
    if (if_req && ls_req) begin
      // On contention the requester served last time yields
      grant_owner = (last_owner == OWN_LS) ? OWN_IF : OWN_LS;
    end else if (ls_req) begin
      grant_owner = OWN_LS;
    end
  end
`else
  logic unused_last;
  assign unused_last = (last_owner == OWN_LS);

  always_comb begin
    grant_owner = OWN_IF;
    if (ls_req) begin
      grant_owner = OWN_LS;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one 64-bit memory port between IFU fetches and LSU loads/stores.
// Build option: MEM_ARB_RR_EN enables round-robin arbitration.
module mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [63:0] if_addr,
  output logic        if_done,
  output logic [63:0] if_rdata,
  input  logic        ls_req,
  input  logic        ls_wen,
  input  logic [63:0] ls_addr,
  input  logic [63:0] ls_wdata,
  input  logic [3:0]  ls_wlen,
  output logic        ls_done,
  output logic [63:0] ls_rdata,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic [63:0] bus_addr,
  output logic        bus_wen,
  output logic [63:0] bus_wdata,
  output logic [3:0]  bus_wlen,
  input  logic        bus_resp,
  input  logic [63:0] bus_rdata
);

  state_e      state_q, state_d;
  owner_e      owner_q, owner_d;
  owner_e      last_q, last_d;
  logic [63:0] addr_q, addr_d;
  logic        wen_q, wen_d;
  logic [63:0] wdata_q, wdata_d;
  logic [3:0]  wlen_q, wlen_d;
  logic [63:0] if_rdata_q, if_rdata_d;
  logic [63:0] ls_rdata_q, ls_rdata_d;

  logic   grant_valid;
  owner_e grant_owner;

  mem_arb_pick u_pick (
    .if_req      (if_req),
    .ls_req      (ls_req),
    .last_owner  (last_q),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    addr_d     = addr_q;
    wen_d      = wen_q;
    wdata_d    = wdata_q;
    wlen_d     = wlen_q;
    if_rdata_d = if_rdata_q;
    ls_rdata_d = ls_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (grant_valid) begin
          state_d = REQ;
          owner_d = grant_owner;
          last_d  = grant_owner;
          if (grant_owner == OWN_LS) begin
            addr_d  = ls_addr;
            wen_d   = ls_wen;
            wdata_d = ls_wdata;
            wlen_d  = ls_wlen;
          end else begin
            addr_d  = if_addr;
            wen_d   = 1'b0;
            wdata_d = '0;
            wlen_d  = FETCH_WLEN;
          end
        end
      end
      REQ: begin
        if (bus_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus_resp) begin
          state_d = RESP;
          // Stores complete without touching the load data
          if (owner_q == OWN_IF) begin
            if_rdata_d = bus_rdata;
          end else if (!wen_q) begin
            ls_rdata_d = bus_rdata;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= OWN_IF;
      last_q     <= OWN_IF;
      addr_q     <= '0;
      wen_q      <= 1'b0;
      wdata_q    <= '0;
      wlen_q     <= '0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      addr_q     <= addr_d;
      wen_q      <= wen_d;
      wdata_q    <= wdata_d;
      wlen_q     <= wlen_d;
      if_rdata_q <= if_rdata_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end

  assign bus_valid = (state_q == REQ);
  assign bus_addr  = addr_q;
  assign bus_wen   = wen_q;
  assign bus_wdata = wdata_q;
  assign bus_wlen  = wlen_q;
  assign if_done   = (state_q == RESP) && (owner_q == OWN_IF);
  assign ls_done   = (state_q == RESP) && (owner_q == OWN_LS);
  assign if_rdata  = if_rdata_q;
  assign ls_rdata  = ls_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
// Contention expectations follow MEM_ARB_RR_EN when it is defined.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_done;
  logic [63:0] if_rdata;
  logic        ls_req;
  logic        ls_wen;
  logic [63:0] ls_addr;
  logic [63:0] ls_wdata;
  logic [3:0]  ls_wlen;
  logic        ls_done;
  logic [63:0] ls_rdata;
  logic        bus_valid;
  logic        bus_ready;
  logic [63:0] bus_addr;
  logic        bus_wen;
  logic [63:0] bus_wdata;
  logic [3:0]  bus_wlen;
  logic        bus_resp;
  logic [63:0] bus_rdata;

  int n_run  = 0;
  int n_fail = 0;

  logic        early;
  logic        acc_valid;
  logic [63:0] acc_addr;
  logic        acc_wen;
  logic [3:0]  acc_wlen;
  logic [63:0] acc_wdata;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_done   (if_done),
    .if_rdata  (if_rdata),
    .ls_req    (ls_req),
    .ls_wen    (ls_wen),
    .ls_addr   (ls_addr),
    .ls_wdata  (ls_wdata),
    .ls_wlen   (ls_wlen),
    .ls_done   (ls_done),
    .ls_rdata  (ls_rdata),
    .bus_valid (bus_valid),
    .bus_ready (bus_ready),
    .bus_addr  (bus_addr),
    .bus_wen   (bus_wen),
    .bus_wdata (bus_wdata),
    .bus_wlen  (bus_wlen),
    .bus_resp  (bus_resp),
    .bus_rdata (bus_rdata)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one access from IDLE: accept after ready_lo stall cycles,
  // respond the cycle after acceptance. Ends in the done cycle.
  task automatic serve(input int ready_lo, input logic [63:0] rd);
    early     = 1'b0;
    bus_ready = 1'b0;
    bus_resp  = 1'b0;
    step();
    for (int i = 0; i < ready_lo; i++) begin
      early = early | if_done | ls_done;
      step();
    end
    acc_valid = bus_valid;
    acc_addr  = bus_addr;
    acc_wen   = bus_wen;
    acc_wlen  = bus_wlen;
    acc_wdata = bus_wdata;
    early     = early | if_done | ls_done;
    bus_ready = 1'b1;
    step();
    bus_ready = 1'b0;
    early     = early | if_done | ls_done;
    bus_resp  = 1'b1;
    bus_rdata = rd;
    step();
    bus_resp  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_run++; if (bus_valid !== 1'b0) begin n_fail++; $display("FAIL rst_bus_valid got %h want 0", bus_valid); end
    n_run++; if (bus_wen !== 1'b0) begin n_fail++; $display("FAIL rst_bus_wen got %h want 0", bus_wen); end
    n_run++; if (bus_addr !== 64'h0) begin n_fail++; $display("FAIL rst_bus_addr got %h want 0", bus_addr); end
    n_run++; if (bus_wdata !== 64'h0) begin n_fail++; $display("FAIL rst_bus_wdata got %h want 0", bus_wdata); end
    n_run++; if (bus_wlen !== 4'h0) begin n_fail++; $display("FAIL rst_bus_wlen got %h want 0", bus_wlen); end
    n_run++; if (if_done !== 1'b0) begin n_fail++; $display("FAIL rst_if_done got %h want 0", if_done); end
    n_run++; if (ls_done !== 1'b0) begin n_fail++; $display("FAIL rst_ls_done got %h want 0", ls_done); end
    n_run++; if (if_rdata !== 64'h0) begin n_fail++; $display("FAIL rst_if_rdata got %h want 0", if_rdata); end
    n_run++; if (ls_rdata !== 64'h0) begin n_fail++; $display("FAIL rst_ls_rdata got %h want 0", ls_rdata); end
    rst = 1'b0;
  endtask

  task automatic test_fetch();
    if_req  = 1'b1;
    if_addr = 64'h0000_0000_8000_0000;
    serve(0, 64'h00000013_00000093);
    n_run++; if (acc_valid !== 1'b1) begin n_fail++; $display("FAIL fetch_valid got %h want 1", acc_valid); end
    n_run++; if (acc_addr !== 64'h8000_0000) begin n_fail++; $display("FAIL fetch_addr got %h want 80000000", acc_addr); end
    n_run++; if (acc_wen !== 1'b0) begin n_fail++; $display("FAIL fetch_wen got %h want 0", acc_wen); end
    n_run++; if (acc_wlen !== 4'd8) begin n_fail++; $display("FAIL fetch_wlen got %h want 8", acc_wlen); end
    n_run++; if (early !== 1'b0) begin n_fail++; $display("FAIL fetch_early_done got %h want 0", early); end
    n_run++; if (if_done !== 1'b1) begin n_fail++; $display("FAIL fetch_if_done got %h want 1", if_done); end
    n_run++; if (ls_done !== 1'b0) begin n_fail++; $display("FAIL fetch_ls_done got %h want 0", ls_done); end
    n_run++; if (if_rdata !== 64'h00000013_00000093) begin n_fail++; $display("FAIL fetch_rdata got %h want 0000001300000093", if_rdata); end
    if_req = 1'b0;
    step();
    n_run++; if (if_done !== 1'b0) begin n_fail++; $display("FAIL fetch_pulse got %h want 0", if_done); end
    n_run++; if (bus_valid !== 1'b0) begin n_fail++; $display("FAIL fetch_idle_valid got %h want 0", bus_valid); end
  endtask

  task automatic test_load();
    ls_req  = 1'b1;
    ls_wen  = 1'b0;
    ls_addr = 64'h8000_2000;
    serve(0, 64'h0123_4567_89AB_CDEF);
    ls_req = 1'b0;
    n_run++; if (acc_wen !== 1'b0) begin n_fail++; $display("FAIL load_wen got %h want 0", acc_wen); end
    n_run++; if (acc_addr !== 64'h8000_2000) begin n_fail++; $display("FAIL load_addr got %h want 80002000", acc_addr); end
    n_run++; if (ls_done !== 1'b1) begin n_fail++; $display("FAIL load_done got %h want 1", ls_done); end
    n_run++; if (ls_rdata !== 64'h0123_4567_89AB_CDEF) begin n_fail++; $display("FAIL load_rdata got %h want 0123456789abcdef", ls_rdata); end
    n_run++; if (if_rdata !== 64'h00000013_00000093) begin n_fail++; $display("FAIL load_if_rdata got %h want 0000001300000093", if_rdata); end
    step();
  endtask

  task automatic test_store();
    ls_req   = 1'b1;
    ls_wen   = 1'b1;
    ls_addr  = 64'h8000_1000;
    ls_wdata = 64'hDEAD_BEEF;
    ls_wlen  = 4'd4;
    serve(0, 64'hFFFF_FFFF_FFFF_FFFF);
    ls_req = 1'b0;
    ls_wen = 1'b0;
    n_run++; if (acc_valid !== 1'b1) begin n_fail++; $display("FAIL store_valid got %h want 1", acc_valid); end
    n_run++; if (acc_addr !== 64'h8000_1000) begin n_fail++; $display("FAIL store_addr got %h want 80001000", acc_addr); end
    n_run++; if (acc_wen !== 1'b1) begin n_fail++; $display("FAIL store_wen got %h want 1", acc_wen); end
    n_run++; if (acc_wdata !== 64'hDEAD_BEEF) begin n_fail++; $display("FAIL store_wdata got %h want deadbeef", acc_wdata); end
    n_run++; if (acc_wlen !== 4'd4) begin n_fail++; $display("FAIL store_wlen got %h want 4", acc_wlen); end
    n_run++; if (ls_done !== 1'b1) begin n_fail++; $display("FAIL store_done got %h want 1", ls_done); end
    n_run++; if (ls_rdata !== 64'h0123_4567_89AB_CDEF) begin n_fail++; $display("FAIL store_rdata got %h want 0123456789abcdef", ls_rdata); end
    step();
  endtask

  task automatic test_contention();
    logic exp_ls;
    logic last_ls;
    rst = 1'b1;
    step();
    rst = 1'b0;
    last_ls = 1'b0;
    if_req  = 1'b1;
    if_addr = 64'h100;
    ls_req  = 1'b1;
    ls_wen  = 1'b0;
    ls_addr = 64'h200;
    for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
      exp_ls = ~last_ls;
`else
      exp_ls = 1'b1;
`endif
      last_ls = exp_ls;
      serve(0, 64'h1000 + 64'(k));
      n_run++; if (acc_addr !== (exp_ls ? 64'h200 : 64'h100)) begin n_fail++; $display("FAIL cont_addr%0d got %h want %h", k, acc_addr, exp_ls ? 64'h200 : 64'h100); end
      n_run++; if (ls_done !== exp_ls) begin n_fail++; $display("FAIL cont_ls_done%0d got %h want %h", k, ls_done, exp_ls); end
      n_run++; if (if_done !== ~exp_ls) begin n_fail++; $display("FAIL cont_if_done%0d got %h want %h", k, if_done, ~exp_ls); end
      if (k == 3) begin
        if_req = 1'b0;
        ls_req = 1'b0;
      end
      step();
    end
  endtask

  task automatic test_stall();
    logic seen;
    seen    = 1'b0;
    ls_req  = 1'b1;
    ls_wen  = 1'b0;
    ls_addr = 64'h3000;
    bus_ready = 1'b0;
    step();
    ls_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_run++; if (bus_addr !== 64'h3000 || bus_valid !== 1'b1) begin n_fail++; $display("FAIL stall_hold%0d got %h/%h want 3000/1", i, bus_addr, bus_valid); end
      seen = seen | ls_done;
      ls_addr = 64'h9000 + 64'(i);
      step();
    end
    n_run++; if (bus_addr !== 64'h3000) begin n_fail++; $display("FAIL stall_addr got %h want 3000", bus_addr); end
    seen = seen | ls_done;
    bus_ready = 1'b1;
    step();
    bus_ready = 1'b0;
    seen = seen | ls_done;
    bus_resp  = 1'b1;
    bus_rdata = 64'h5555_AAAA_0000_FFFF;
    step();
    bus_resp = 1'b0;
    n_run++; if (seen !== 1'b0) begin n_fail++; $display("FAIL stall_early_done got %h want 0", seen); end
    n_run++; if (ls_done !== 1'b1) begin n_fail++; $display("FAIL stall_done_t8 got %h want 1", ls_done); end
    n_run++; if (ls_rdata !== 64'h5555_AAAA_0000_FFFF) begin n_fail++; $display("FAIL stall_rdata got %h want 5555aaaa0000ffff", ls_rdata); end
    step();
  endtask

  task automatic test_reset_wait();
    logic seen;
    seen    = 1'b0;
    ls_req  = 1'b1;
    ls_wen  = 1'b0;
    ls_addr = 64'h4000;
    step();
    ls_req = 1'b0;
    bus_ready = 1'b1;
    step();
    bus_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_run++; if (bus_valid !== 1'b0) begin n_fail++; $display("FAIL rstw_valid got %h want 0", bus_valid); end
    n_run++; if (ls_done !== 1'b0) begin n_fail++; $display("FAIL rstw_done got %h want 0", ls_done); end
    bus_resp  = 1'b1;
    bus_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    step();
    bus_resp = 1'b0;
    for (int i = 0; i < 3; i++) begin
      seen = seen | ls_done | if_done | bus_valid;
      step();
    end
    n_run++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rstw_late_resp got %h want 0", seen); end
    n_run++; if (ls_rdata !== 64'h0) begin n_fail++; $display("FAIL rstw_rdata got %h want 0", ls_rdata); end
  endtask

  task automatic test_idle_resp();
    logic seen;
    seen      = 1'b0;
    bus_resp  = 1'b1;
    bus_rdata = 64'h7777_7777_7777_7777;
    for (int i = 0; i < 2; i++) begin
      step();
      seen = seen | if_done | ls_done | bus_valid;
    end
    bus_resp = 1'b0;
    n_run++; if (seen !== 1'b0) begin n_fail++; $display("FAIL idle_resp_activity got %h want 0", seen); end
    n_run++; if (if_rdata !== 64'h0) begin n_fail++; $display("FAIL idle_resp_rdata got %h want 0", if_rdata); end
    if_req  = 1'b1;
    if_addr = 64'h8000_0040;
    serve(0, 64'h1234_5678_9ABC_DEF0);
    if_req = 1'b0;
    n_run++; if (early !== 1'b0 || if_done !== 1'b1) begin n_fail++; $display("FAIL idle_resp_next got %h/%h want 0/1", early, if_done); end
    n_run++; if (if_rdata !== 64'h1234_5678_9ABC_DEF0) begin n_fail++; $display("FAIL idle_resp_next_rdata got %h want 123456789abcdef0", if_rdata); end
    step();
  endtask

  initial begin
    rst       = 1'b1;
    if_req    = 1'b0;
    if_addr   = '0;
    ls_req    = 1'b0;
    ls_wen    = 1'b0;
    ls_addr   = '0;
    ls_wdata  = '0;
    ls_wlen   = 4'd8;
    bus_ready = 1'b0;
    bus_resp  = 1'b0;
    bus_rdata = '0;
    test_reset();
    test_fetch();
    test_load();
    test_store();
    test_contention();
    test_stall();
    test_reset_wait();
    test_idle_resp();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester memory-port arbiter that shares the single 64-bit data bus between the instruction-fetch unit (IFU) and the memory stage's load/store path. It sits between the pipeline's `mm_*` interface and the external memory/bus model. It captures one request at a time and drives a valid/ready address phase on the bus. It waits for the response, then returns raw 64-bit read data to the owning requester with a one-cycle done pulse. Load-data sign/zero extension stays in the memory stage; this block moves raw bytes only.

## Interface
- No parameters; address/data width fixed at 64 bits.
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk` input, 1 bit: sole clock, rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `if_req` input, 1 bit: IFU requests an 8-byte read.
- `if_addr` input, 64 bits: fetch address.
- `if_done` output, 1 bit: one-cycle pulse; `if_rdata` valid.
- `if_rdata` output, 64 bits: fetch data, held until the next IFU done.
- `ls_req` input, 1 bit: load/store request (the `mm_ren | mm_wen` of the memory stage).
- `ls_wen` input, 1 bit: 1 = store, 0 = load.
- `ls_addr` input, 64 bits: data address.
- `ls_wdata` input, 64 bits: store data.
- `ls_wlen` input, 4 bits: store byte count, one of 1, 2, 4 or 8.
- `ls_done` output, 1 bit: one-cycle pulse on completion of a load or store.
- `ls_rdata` output, 64 bits: raw load data, held until the next LSU done.
- `bus_valid` output, 1 bit: address phase valid.
- `bus_ready` input, 1 bit: bus accepts the address phase.
- `bus_addr` output, 64 bits: captured address.
- `bus_wen` output, 1 bit: captured write enable.
- `bus_wdata` output, 64 bits: captured store data.
- `bus_wlen` output, 4 bits: captured write length; 8 for fetches.
- `bus_resp` input, 1 bit: response valid. Never asserted in the cycle the address phase is accepted.
- `bus_rdata` input, 64 bits: read data, valid with `bus_resp`.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: if any `*_req` is high, the block picks the winner and captures its fields into registers. It records the owner and goes to REQ. If no request is high, it stays in IDLE.
- REQ: `bus_valid`=1 with the captured fields. On `bus_valid & bus_ready` it goes to WAIT. Until then the fields are held constant.
- WAIT: on `bus_resp` it captures `bus_rdata` into the owner's rdata register (loads and fetches only) and goes to RESP.
- RESP: the owner's `*_done`=1 for exactly this cycle, then the FSM returns to IDLE.
- Fetches always issue `bus_wen`=0 and `bus_wlen`=8.
- Stores leave `ls_rdata` unchanged.
- Any `*_req` high while the FSM is in IDLE is a new access. A requester with no further access must deassert `*_req` no later than its done cycle.
- Request fields are sampled only in IDLE. Changes to them in REQ, WAIT or RESP have no effect.
- Default arbitration is fixed priority: LSU wins when both requesters are high.
- `last_owner` register: updated on every grant; reset value is IFU.
- `bus_resp` in IDLE, REQ or RESP is ignored.
- `ls_wlen` values other than 1, 2, 4 or 8 are passed through unchecked.

## Timing
- Reset values: state IDLE, `bus_valid`=0, `bus_wen`=0, `bus_addr`/`bus_wdata`=0, `bus_wlen`=0, `if_done`=`ls_done`=0, `if_rdata`=`ls_rdata`=0, `last_owner`=IFU.
- Reset mid-operation abandons the access: no done pulse, and `bus_valid` drops the next cycle.
- Minimum latency, with `bus_ready` high and `bus_resp` one cycle after acceptance: request seen at cycle t, REQ at t+1, WAIT at t+2, RESP/done at t+3.
- The earliest next grant is decided at t+4, so back-to-back throughput is one access per 4 cycles.
- Each extra `bus_ready`-low cycle or `bus_resp` wait cycle adds exactly one cycle of latency.
- All outputs are registered or decoded from registered state. There is no combinational path from bus inputs to requester outputs.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration. On contention in IDLE, the requester that is not `last_owner` wins. Single requests are granted regardless of `last_owner`.
- `MEM_ARB_RR_EN` undefined: fixed LSU priority. `last_owner` still exists but does not affect the grant.

## Structure
- Package `mem_arb_pkg`:
  - state enum (IDLE/REQ/WAIT/RESP);
  - owner enum (OWN_IF/OWN_LS);
  - constant `FETCH_WLEN`=4'd8.
- Sub-module `mem_arb_pick`: combinational. Inputs `if_req`, `ls_req`, `last_owner`; outputs `grant_valid` and `grant_owner`. It holds the `MEM_ARB_RR_EN` conditional.
- The FSM and capture registers live in the top module.

## Test plan
- Single fetch at `if_addr`=0x8000_0000, `bus_ready`=1, `bus_resp` one cycle later with rdata 0x00000013_00000093 -> `if_done` pulses at t+3 and `if_rdata` equals that value.
- Store with `ls_wen`=1, `ls_addr`=0x8000_1000, `ls_wdata`=0xDEAD_BEEF, `ls_wlen`=4 -> bus shows those exact fields with `bus_wen`=1, `ls_done` pulses, `ls_rdata` is unchanged.
- `if_req` and `ls_req` held high together for 4 accesses:
  - without `MEM_ARB_RR_EN`: all 4 grants go to LSU;
  - with it: grants alternate LS, IF, LS, IF.
- `bus_ready` held low 5 cycles in REQ while `ls_addr` is changed -> `bus_addr` keeps the captured value and done arrives at t+8.
- `rst` asserted during WAIT -> the next cycle is IDLE with `bus_valid`=0. A late `bus_resp` produces no done and leaves rdata unchanged.
- `bus_resp` asserted while in IDLE -> no state change and no done.
